// File: rtl/mbf_scale_cfg_sequencer.sv
// Scale-stage configuration master: walks the selected slaves in ascending order through the
// isConfig/ACK/ConfigDone handshake with timeout supervision. Optional clamp: MBF_SCALE_CFG_CLAMP_EN.
module mbf_scale_cfg_sequencer #(
  parameter int NUM_SLAVES     = 4,
  parameter int CFG_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SHIFT_MAX      = 30
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  Cfg_Start,
  input  logic [CFG_WIDTH-1:0]  Cfg_Value,
  input  logic [NUM_SLAVES-1:0] Cfg_Mask,
  output logic [NUM_SLAVES-1:0] Slave_isConfig,
  output logic [CFG_WIDTH-1:0]  Slave_Config_Data,
  input  logic [NUM_SLAVES-1:0] Slave_ACK,
  input  logic [NUM_SLAVES-1:0] Slave_Done,
  output logic                  Busy,
  output logic                  Cfg_Done,
  output logic                  Cfg_Error,
`ifdef MBF_SCALE_CFG_CLAMP_EN
  output logic                  Cfg_Clamped,
`endif
  output logic [3:0]            Err_Slave_Idx
);

  localparam int IDXW = 5;
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDXW-1:0] IDX_END  = IDXW'(NUM_SLAVES);
  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT_DONE,
    RELEASE,
    FINISH
  } state_t;

  state_t                state, stateNext;
  logic [IDXW-1:0]       idx;
  logic [CNTW-1:0]       tmoCnt;
  logic [CFG_WIDTH-1:0]  valLat, valIn;
  logic [NUM_SLAVES-1:0] maskLat, sel;
  logic                  accept, idxInc, tmoHit, tmoLast, waiting;
  logic                  curAck, curDone, curMask;

  // One-hot select; shifts out to zero once the index runs past the last slave.
  assign sel     = NUM_SLAVES'(1) << idx;
  assign curAck  = |(Slave_ACK & sel);
  assign curDone = |(Slave_Done & sel);
  assign curMask = |(maskLat & sel);
  assign tmoLast = (tmoCnt == TMO_LAST);
  assign waiting = (state == REQ) || (state == WAIT_DONE) || (state == RELEASE);

`ifdef MBF_SCALE_CFG_CLAMP_EN
  logic clampHit;
  assign clampHit = (Cfg_Value > CFG_WIDTH'(SHIFT_MAX));
  assign valIn    = clampHit ? CFG_WIDTH'(SHIFT_MAX) : Cfg_Value;
`else
  assign valIn    = Cfg_Value;
`endif

  // Combinational outputs so an async reset or a timeout drops isConfig in the same cycle.
  assign Slave_isConfig    = ((state == REQ) || (state == WAIT_DONE)) ? sel : '0;
  assign Slave_Config_Data = waiting ? valLat : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    stateNext = state;
    accept    = 1'b0;
    idxInc    = 1'b0;
    tmoHit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Cfg_Start) begin
          accept    = 1'b1;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        if (idx >= IDX_END) stateNext = FINISH;
        else if (curMask)   stateNext = REQ;
        else                idxInc    = 1'b1;
      end
      REQ: begin
        // A slave re-entering config from its work state may answer Done without ACK.
        if (curDone)      stateNext = RELEASE;
        else if (curAck)  stateNext = WAIT_DONE;
        else if (tmoLast) tmoHit    = 1'b1;
      end
      WAIT_DONE: begin
        if (curDone)      stateNext = RELEASE;
        else if (tmoLast) tmoHit    = 1'b1;
      end
      RELEASE: begin
        if (!curAck) begin
          idxInc    = 1'b1;
          stateNext = SCAN;
        end else if (tmoLast) begin
          tmoHit = 1'b1;
        end
      end
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (tmoHit) stateNext = FINISH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idx           <= '0;
      tmoCnt        <= '0;
      valLat        <= '0;
      maskLat       <= '0;
      Busy          <= 1'b0;
      Cfg_Done      <= 1'b0;
      Cfg_Error     <= 1'b0;
      Err_Slave_Idx <= '0;
`ifdef MBF_SCALE_CFG_CLAMP_EN
      Cfg_Clamped   <= 1'b0;
`endif
    end else begin
      Cfg_Done <= (state == FINISH);
      if (accept) begin
        valLat        <= valIn;
        maskLat       <= Cfg_Mask;
        idx           <= '0;
        Busy          <= 1'b1;
        Cfg_Error     <= 1'b0;
        Err_Slave_Idx <= '0;
`ifdef MBF_SCALE_CFG_CLAMP_EN
        Cfg_Clamped   <= clampHit;
`endif
      end else if (state == FINISH) begin
        Busy <= 1'b0;
      end
      if (idxInc) idx <= idx + IDXW'(1);
      if (tmoHit) begin
        Cfg_Error     <= 1'b1;
        Err_Slave_Idx <= idx[3:0];
      end
      // Counter restarts on every state entry and only runs in the three wait states.
      tmoCnt <= (waiting && (stateNext == state)) ? tmoCnt + CNTW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mbf_scale_cfg_sequencer.sv
// Directed bench for mbf_scale_cfg_sequencer with a behavioural slave bank and handshake monitor.
module tb_mbf_scale_cfg_sequencer;

  logic        CLK;
  logic        nRST;
  logic        Cfg_Start;
  logic [23:0] Cfg_Value;
  logic [3:0]  Cfg_Mask;
  logic [3:0]  Slave_isConfig;
  logic [23:0] Slave_Config_Data;
  logic [3:0]  Slave_ACK;
  logic [3:0]  Slave_Done;
  logic        Busy;
  logic        Cfg_Done;
  logic        Cfg_Error;
  logic [3:0]  Err_Slave_Idx;
`ifdef MBF_SCALE_CFG_CLAMP_EN
  logic        Cfg_Clamped;
`endif

  mbf_scale_cfg_sequencer dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .Cfg_Start         (Cfg_Start),
    .Cfg_Value         (Cfg_Value),
    .Cfg_Mask          (Cfg_Mask),
    .Slave_isConfig    (Slave_isConfig),
    .Slave_Config_Data (Slave_Config_Data),
    .Slave_ACK         (Slave_ACK),
    .Slave_Done        (Slave_Done),
    .Busy              (Busy),
    .Cfg_Done          (Cfg_Done),
    .Cfg_Error         (Cfg_Error),
`ifdef MBF_SCALE_CFG_CLAMP_EN
    .Cfg_Clamped       (Cfg_Clamped),
`endif
    .Err_Slave_Idx     (Err_Slave_Idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Slave behaviour: 0 = ACK then Done, 1 = never answers, 2 = Done without ACK.
  int          mode      [4];
  int          scnt      [4];
  int          reqCount  [4];
  int          hiCycles  [4];
  int          reqTime   [4];
  logic [23:0] dataSeen  [4];
  logic [3:0]  prevIsCfg;
  int          cycle;
  int          doneCount;
  logic        multiHot;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clearStats();
    for (int i = 0; i < 4; i++) begin
      reqCount[i] = 0;
      hiCycles[i] = 0;
      reqTime[i]  = 0;
      dataSeen[i] = '0;
    end
    doneCount = 0;
    multiHot  = 1'b0;
  endtask

  task automatic startPass(input logic [23:0] v, input logic [3:0] m);
    Cfg_Value = v;
    Cfg_Mask  = m;
    Cfg_Start = 1'b1;
    @(negedge CLK);
    Cfg_Start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int lat);
    lat = 0;
    while (!Cfg_Done && lat < budget) begin
      @(negedge CLK);
      lat++;
    end
    check("done_within_budget", 32'(lat < budget), 32'd1);
  endtask

  // Slave bank and monitor, evaluated on the falling edge away from DUT updates.
  initial begin
    cycle     = 0;
    prevIsCfg = '0;
    Slave_ACK  = '0;
    Slave_Done = '0;
    for (int i = 0; i < 4; i++) begin
      mode[i] = 0;
      scnt[i] = 0;
    end
    forever begin
      @(negedge CLK);
      cycle++;
      if (Cfg_Done) doneCount++;
      if ($countones(Slave_isConfig) > 1) multiHot = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (Slave_isConfig[i]) begin
          hiCycles[i]++;
          if (!prevIsCfg[i]) begin
            reqCount[i]++;
            dataSeen[i] = Slave_Config_Data;
            reqTime[i]  = cycle;
          end
          scnt[i]++;
          case (mode[i])
            0: begin
              if (scnt[i] == 1) Slave_ACK[i] = 1'b1;
              Slave_Done[i] = (scnt[i] == 2);
            end
            2:       Slave_Done[i] = (scnt[i] == 1);
            default: ;
          endcase
        end else begin
          Slave_ACK[i]  = 1'b0;
          Slave_Done[i] = 1'b0;
          scnt[i]       = 0;
        end
      end
      prevIsCfg = Slave_isConfig;
    end
  end

  initial begin
    int lat;
    nRST      = 1'b0;
    Cfg_Start = 1'b0;
    Cfg_Value = '0;
    Cfg_Mask  = '0;
    clearStats();
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Cfg_Done), 32'd0);
    check("rst_error", 32'(Cfg_Error), 32'd0);
    check("rst_err_idx", 32'(Err_Slave_Idx), 32'd0);
    check("rst_iscfg", 32'(Slave_isConfig), 32'd0);
    check("rst_data", 32'(Slave_Config_Data), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Mask 0101, value 5: slaves 0 and 2 only, ascending
    clearStats();
    startPass(24'd5, 4'b0101);
    check("t1_busy_after_start", 32'(Busy), 32'd1);
    waitDone(200, lat);
    check("t1_latency", 32'(lat), 32'd12);
    check("t1_busy_at_done", 32'(Busy), 32'd0);
    check("t1_error", 32'(Cfg_Error), 32'd0);
    check("t1_req0", 32'(reqCount[0]), 32'd1);
    check("t1_req1", 32'(reqCount[1]), 32'd0);
    check("t1_req2", 32'(reqCount[2]), 32'd1);
    check("t1_req3", 32'(reqCount[3]), 32'd0);
    check("t1_data0", 32'(dataSeen[0]), 32'd5);
    check("t1_data2", 32'(dataSeen[2]), 32'd5);
    check("t1_order", 32'(reqTime[0] < reqTime[2]), 32'd1);
    check("t1_hi0", 32'(hiCycles[0]), 32'd2);
    @(negedge CLK);
    check("t1_done_pulse_width", 32'(Cfg_Done), 32'd0);
    check("t1_done_count", 32'(doneCount), 32'd1);
    check("t1_multihot", 32'(multiHot), 32'd0);
    check("t1_idle_data", 32'(Slave_Config_Data), 32'd0);

    // Empty mask: NUM_SLAVES+2 cycles, no requests
    clearStats();
    startPass(24'd9, 4'b0000);
    waitDone(200, lat);
    check("t2_latency", 32'(lat), 32'd6);
    check("t2_no_req", 32'(reqCount[0] + reqCount[1] + reqCount[2] + reqCount[3]), 32'd0);

    // Slave 1 never answers: timeout after 64 cycles in REQ
    clearStats();
    mode[1] = 1;
    startPass(24'd9, 4'b1111);
    waitDone(300, lat);
    check("t3_latency", 32'(lat), 32'd70);
    check("t3_error", 32'(Cfg_Error), 32'd1);
    check("t3_err_idx", 32'(Err_Slave_Idx), 32'd1);
    check("t3_hi1", 32'(hiCycles[1]), 32'd64);
    check("t3_req2", 32'(reqCount[2]), 32'd0);
    check("t3_req3", 32'(reqCount[3]), 32'd0);
    check("t3_iscfg_dropped", 32'(Slave_isConfig), 32'd0);
    repeat (4) @(negedge CLK);
    check("t3_error_sticky", 32'(Cfg_Error), 32'd1);
    check("t3_done_count", 32'(doneCount), 32'd1);
    mode[1] = 0;
    startPass(24'd1, 4'b0000);
    check("t3_error_cleared", 32'(Cfg_Error), 32'd0);
    check("t3_err_idx_cleared", 32'(Err_Slave_Idx), 32'd0);
    waitDone(200, lat);

    // Cfg_Start while Busy is ignored
    clearStats();
    startPass(24'd3, 4'b1111);
    repeat (3) @(negedge CLK);
    startPass(24'd7, 4'b0001);
    waitDone(200, lat);
    check("t4_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_data%0d", i), 32'(dataSeen[i]), 32'd3);
      check($sformatf("t4_req%0d", i), 32'(reqCount[i]), 32'd1);
    end
    repeat (10) @(negedge CLK);
    check("t4_no_second_pass", 32'(doneCount), 32'd1);
    check("t4_idle_busy", 32'(Busy), 32'd0);
    check("t4_multihot", 32'(multiHot), 32'd0);

    // Done without ACK (re-config path)
    clearStats();
    mode[2] = 2;
    startPass(24'd11, 4'b0100);
    waitDone(200, lat);
    check("t5_latency", 32'(lat), 32'd8);
    check("t5_error", 32'(Cfg_Error), 32'd0);
    check("t5_data2", 32'(dataSeen[2]), 32'd11);
    check("t5_hi2", 32'(hiCycles[2]), 32'd1);
    mode[2] = 0;

    // Value above SHIFT_MAX
    clearStats();
    startPass(24'd40, 4'b0001);
    waitDone(200, lat);
    check("t6_latency", 32'(lat), 32'd9);
`ifdef MBF_SCALE_CFG_CLAMP_EN
    check("t6_clamped_data", 32'(dataSeen[0]), 32'd30);
    check("t6_clamped_flag", 32'(Cfg_Clamped), 32'd1);
    startPass(24'd30, 4'b0000);
    check("t6_clamp_cleared", 32'(Cfg_Clamped), 32'd0);
    waitDone(200, lat);
`else
    check("t6_pass_through", 32'(dataSeen[0]), 32'd40);
`endif

    // Reset mid-pass drops isConfig at once
    mode[0] = 1;
    startPass(24'd5, 4'b0001);
    repeat (3) @(negedge CLK);
    check("t7_in_req", 32'(Slave_isConfig), 32'd1);
    nRST = 1'b0;
    #1;
    check("t7_rst_iscfg", 32'(Slave_isConfig), 32'd0);
    check("t7_rst_busy", 32'(Busy), 32'd0);
    check("t7_rst_data", 32'(Slave_Config_Data), 32'd0);
    @(negedge CLK);
    nRST    = 1'b1;
    mode[0] = 0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbf_scale_cfg_sequencer.md
Name: mbf_scale_cfg_sequencer

Overview:
- Configuration master for a bank of FIR output-scale stages in the multichannel MHBF filter chain.
- Takes one host scale value plus a target mask and loads the value into each selected slave in ascending index order.
- Uses the per-slave isConfig / ACK / ConfigDone handshake, with timeout supervision and one-line status reporting back to the host register block.

Parameters:
- NUM_SLAVES, 4, number of scale stages driven (1..16).
- CFG_WIDTH, 24, width of the config word (shift amount) sent to each slave.
- TIMEOUT_CYCLES, 64, maximum CLK cycles spent in any single wait state before an error is raised.
- SHIFT_MAX, 30, largest legal shift value (used only by the optional feature).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- Cfg_Start  in  1  single-cycle request to begin a configuration pass.
- Cfg_Value  in  CFG_WIDTH  shift value; sampled only on an accepted Cfg_Start.
- Cfg_Mask  in  NUM_SLAVES  bit i set selects slave i; sampled only on an accepted Cfg_Start.
- Slave_isConfig  out  NUM_SLAVES  one-hot config request to each slave.
- Slave_Config_Data  out  CFG_WIDTH  config word, shared by all slaves.
- Slave_ACK  in  NUM_SLAVES  per-slave acknowledge.
- Slave_Done  in  NUM_SLAVES  per-slave config-done pulse.
- Busy  out  1  high while a pass is in progress.
- Cfg_Done  out  1  one-cycle pulse when a pass completes, with or without error.
- Cfg_Error  out  1  sticky timeout flag; cleared on the next accepted Cfg_Start.
- Err_Slave_Idx  out  4  index of the slave that timed out; valid while Cfg_Error is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; slave index 0; timeout counter 0. Reset asserted mid-pass aborts immediately and drops all Slave_isConfig lines.
- IDLE:
  - Cfg_Start latches Cfg_Value and Cfg_Mask, clears Cfg_Error and Err_Slave_Idx, sets index to 0, moves to SCAN.
  - Busy rises on the cycle after Cfg_Start.
  - Cfg_Start while Busy is high is ignored; the latched value and mask are not disturbed.
- SCAN (1 cycle per index):
  - Latched mask bit for the current index set: go to REQ.
  - Mask bit clear: increment the index.
  - Index past NUM_SLAVES-1: go to FINISH.
- REQ:
  - Drive Slave_isConfig[idx]=1 and Slave_Config_Data = latched value.
  - Wait for Slave_ACK[idx] or Slave_Done[idx]. A slave that is re-entering config from its work state may skip ACK. Seeing Done here goes straight to RELEASE.
  - On ACK: go to WAIT_DONE.
- WAIT_DONE: keep isConfig and data stable; Slave_Done[idx] goes to RELEASE.
- RELEASE:
  - Drop Slave_isConfig[idx].
  - Wait for Slave_ACK[idx]==0, then increment the index and go to SCAN.
- FINISH: pulse Cfg_Done for 1 cycle, drop Busy in the same cycle, return to IDLE.
- Timeout:
  - Counter clears on every state entry and counts in REQ, WAIT_DONE and RELEASE.
  - At TIMEOUT_CYCLES-1: set Cfg_Error, load Err_Slave_Idx=idx, drop all isConfig lines, go to FINISH.
  - The remaining slaves are not configured.
- Slave_Config_Data:
  - Holds the latched value from REQ entry through RELEASE.
  - Is 0 in IDLE.
- Slave_isConfig:
  - Is never multi-hot.
  - Never re-asserts to the same slave in the same pass.
- Latency:
  - Empty mask: Cfg_Start to Cfg_Done = 2+NUM_SLAVES cycles.
  - Each selected slave adds its handshake time plus 1 RELEASE cycle minimum.

Optional Feature:
- Macro: MBF_SCALE_CFG_CLAMP_EN.
- Defined:
  - On an accepted Cfg_Start, a Cfg_Value greater than SHIFT_MAX is latched as SHIFT_MAX.
  - Extra output port Cfg_Clamped (1 bit, reset 0) is set on clamp and cleared on the next accepted Cfg_Start.
- Undefined: the value is passed through unmodified and the port does not exist.

Test Plan:
- Mask=4'b0101, value=5, slaves respond ACK after 1 cycle and Done 1 cycle later. Required: slave 0 and then slave 2 each see isConfig with data=5; slaves 1 and 3 are never requested; one Cfg_Done pulse; Cfg_Error=0.
- Mask=0. Required: Cfg_Done exactly NUM_SLAVES+2 cycles after Cfg_Start; no isConfig activity.
- Slave 1 never raises ACK, mask=4'b1111. Required: Cfg_Error=1 and Err_Slave_Idx=1 after 64 cycles in REQ; slaves 2 and 3 untouched; Cfg_Done pulses once; next Cfg_Start clears the error.
- Cfg_Start with value=7 while a pass with value=3 is Busy. Required: ignored; all selected slaves receive 3.
- Slave answers Done without ACK (re-config path). Required: the sequencer advances through RELEASE normally with no timeout.
- MBF_SCALE_CFG_CLAMP_EN defined, value=40. Required: slaves receive 30 and Cfg_Clamped=1. Without the macro, slaves receive 40.
